// File: rtl/uart_rx_param.sv
// uart_rx_param: parametrised UART receiver.
// Frame format (5..8 data bits, none/even/odd parity, 1..2 stop bits) is set
// at elaboration time. The line is double-flop synchronised and every bit is
// decided by a 3-sample majority vote around the bit centre. Received bytes
// are delivered through a valid/ready holding register with parity-error,
// framing-error and overrun reporting.
module uart_rx_param #(
  parameter int CLK_FREQ_HZ = 20_000_000,
  parameter int BAUD        = 256000,
  parameter int DATA_BITS   = 8,
  parameter int PARITY      = 0,
  parameter int STOP_BITS   = 1
) (
  input  logic       SYS_CLK,
  input  logic       RST_N,
  input  logic       Rxd,
  input  logic       rx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_parity_err,
  output logic       rx_frame_err,
  output logic       rx_overrun,
  output logic       rx_busy
);

  // Bit timing: BIT_CNT clocks per bit, the vote window sits around HALF.
  localparam int BIT_CNT = CLK_FREQ_HZ / BAUD;
  localparam int HALF    = BIT_CNT / 2;
  localparam int CNT_W   = $clog2(BIT_CNT);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIT_CNT - 1);
  localparam logic [CNT_W-1:0] HALF_M1  = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0] HALF_P0  = CNT_W'(HALF);
  localparam logic [CNT_W-1:0] HALF_P1  = CNT_W'(HALF + 1);

  // Last index of the data-bit and stop-bit loops.
  localparam logic [2:0] DATA_LAST = 3'(DATA_BITS - 1);
  localparam logic [2:0] STOP_LAST = 3'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_t;

  state_t           state;

  // Synchroniser and edge-detect history.
  logic             sync1;
  logic             sync2;
  logic             rxs_d;
  logic             rxs;

  // Bit timing and the two early vote samples.
  logic [CNT_W-1:0] baud_cnt;
  logic [2:0]       bit_idx;
  logic             samp0;
  logic             samp1;

  // Frame being assembled.
  logic [7:0]       data_q;
  logic             par_err_q;
  logic             frame_err_q;

  // Decoded timing and control events.
  logic             start_edge;
  logic             sample_pt;
  logic             wrap;
  logic             bit_val;
  logic             frame_done;
  logic             done_frame_err;
  logic             accept;

  assign rxs        = sync2;
  assign start_edge = (state == ST_IDLE) && rxs_d && !rxs;
  assign sample_pt  = (baud_cnt == HALF_P1);
  assign wrap       = (baud_cnt == CNT_LAST);

  // Majority of the samples at HALF-1, HALF and the live value at HALF+1.
  assign bit_val    = (samp0 & samp1) | (samp0 & rxs) | (samp1 & rxs);

  // The frame completes at the vote of the last stop bit, not at its end,
  // so a start edge arriving right after the stop bit is not missed.
  assign frame_done     = (state == ST_STOP) && sample_pt && (bit_idx == STOP_LAST);
  assign done_frame_err = frame_err_q | ~bit_val;
  assign accept         = rx_valid & rx_ready;

  assign rx_busy    = (state != ST_IDLE);

  // Two-flop synchroniser plus one history flop for falling-edge detection.
  always_ff @(posedge SYS_CLK or negedge RST_N) begin
    if (!RST_N) begin
      // NOTE: the synchroniser resets to the idle line level (1) so that
      // releasing reset never looks like a falling edge / start bit.
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      rxs_d <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments make all three flops update from
      // their pre-edge values, giving a true shift chain rather than a wire.
      sync1 <= Rxd;
      sync2 <= sync1;
      rxs_d <= sync2;
    end
  end

  // Capture the first two votes of each bit; the third is taken live.
  always_ff @(posedge SYS_CLK or negedge RST_N) begin
    if (!RST_N) begin
      samp0 <= 1'b0;
      samp1 <= 1'b0;
    end else begin
      if (baud_cnt == HALF_M1) samp0 <= rxs;
      if (baud_cnt == HALF_P0) samp1 <= rxs;
    end
  end

  // Receive FSM: bit timing, data assembly, parity and stop-bit checks.
  always_ff @(posedge SYS_CLK or negedge RST_N) begin
    if (!RST_N) begin
      state       <= ST_IDLE;
      baud_cnt    <= '0;
      bit_idx     <= '0;
      data_q      <= '0;
      par_err_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      // The bit counter free-runs in every active state; transitions that
      // return to IDLE override it back to zero below.
      if (state != ST_IDLE) begin
        baud_cnt <= wrap ? '0 : baud_cnt + 1'b1;
      end

      case (state)
        ST_IDLE: begin
          if (start_edge) begin
            state       <= ST_START;
            baud_cnt    <= '0;
            bit_idx     <= '0;
            data_q      <= '0;
            par_err_q   <= 1'b0;
            frame_err_q <= 1'b0;
          end
        end

        ST_START: begin
          if (sample_pt && bit_val) begin
            // A low pulse that is high again at the bit centre is a glitch.
            state    <= ST_IDLE;
            baud_cnt <= '0;
          end else if (wrap) begin
            state <= ST_DATA;
          end
        end

        ST_DATA: begin
          // LSB first; unused upper bits stay 0 from the clear at start.
          if (sample_pt) data_q[bit_idx] <= bit_val;
          if (wrap) begin
            if (bit_idx == DATA_LAST) begin
              bit_idx <= '0;
              state   <= (PARITY != 0) ? ST_PARITY : ST_STOP;
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end
        end

        ST_PARITY: begin
          // Even: data^parity must be 0. Odd: data^parity must be 1.
          if (sample_pt) begin
            par_err_q <= (PARITY == 2) ? ~(^data_q ^ bit_val) : (^data_q ^ bit_val);
          end
          if (wrap) state <= ST_STOP;
        end

        ST_STOP: begin
          if (sample_pt && !bit_val) frame_err_q <= 1'b1;
          if (frame_done) begin
            state    <= ST_IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
          end else if (wrap) begin
            bit_idx <= bit_idx + 1'b1;
          end
        end

        default: begin
          state    <= ST_IDLE;
          baud_cnt <= '0;
          bit_idx  <= '0;
        end
      endcase
    end
  end

  // Holding register with valid/ready handshake and overrun detection.
  always_ff @(posedge SYS_CLK or negedge RST_N) begin
    if (!RST_N) begin
      rx_data       <= '0;
      rx_valid      <= 1'b0;
      rx_parity_err <= 1'b0;
      rx_frame_err  <= 1'b0;
      rx_overrun    <= 1'b0;
    end else begin
      rx_overrun <= 1'b0;
      if (frame_done && (!rx_valid || accept)) begin
        // Empty register, or the held byte leaves this very cycle.
        rx_data       <= data_q;
        rx_parity_err <= par_err_q;
        rx_frame_err  <= done_frame_err;
        rx_valid      <= 1'b1;
      end else if (frame_done) begin
        // Held byte not taken: drop the new frame and flag it.
        rx_overrun <= 1'b1;
      end else if (accept) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_param.sv
// tb_uart_rx_param: directed plus randomised bench for uart_rx_param.
// Four receivers with different frame formats share one clock; each has its
// own serial line and ready input. Expected results come from a frame-level
// model (masked data, parity by bit counting, stop-bit inspection).
module tb_uart_rx_param;

  localparam int BIT_CNT = 20_000_000 / 256000;
  localparam int HALF    = BIT_CNT / 2;
  localparam int NU      = 4;

  // Frame format of each unit: data bits, parity mode, stop bits.
  localparam int NB [NU] = '{8, 8, 8, 5};
  localparam int PM [NU] = '{0, 1, 2, 0};
  localparam int NS [NU] = '{1, 1, 2, 1};

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rxd      [NU];
  logic       ready    [NU];
  logic [7:0] rx_data  [NU];
  logic       rx_valid [NU];
  logic       rx_perr  [NU];
  logic       rx_ferr  [NU];
  logic       rx_ovr   [NU];
  logic       rx_busy  [NU];

  int checks = 0;
  int errors = 0;

  always #25 clk = ~clk;

  uart_rx_param #(.CLK_FREQ_HZ(20_000_000), .BAUD(256000), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_dut0 (
    .SYS_CLK(clk), .RST_N(rst_n), .Rxd(rxd[0]), .rx_ready(ready[0]), .rx_data(rx_data[0]),
    .rx_valid(rx_valid[0]), .rx_parity_err(rx_perr[0]), .rx_frame_err(rx_ferr[0]),
    .rx_overrun(rx_ovr[0]), .rx_busy(rx_busy[0]));

  uart_rx_param #(.CLK_FREQ_HZ(20_000_000), .BAUD(256000), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u_dut1 (
    .SYS_CLK(clk), .RST_N(rst_n), .Rxd(rxd[1]), .rx_ready(ready[1]), .rx_data(rx_data[1]),
    .rx_valid(rx_valid[1]), .rx_parity_err(rx_perr[1]), .rx_frame_err(rx_ferr[1]),
    .rx_overrun(rx_ovr[1]), .rx_busy(rx_busy[1]));

  uart_rx_param #(.CLK_FREQ_HZ(20_000_000), .BAUD(256000), .DATA_BITS(8), .PARITY(2), .STOP_BITS(2)) u_dut2 (
    .SYS_CLK(clk), .RST_N(rst_n), .Rxd(rxd[2]), .rx_ready(ready[2]), .rx_data(rx_data[2]),
    .rx_valid(rx_valid[2]), .rx_parity_err(rx_perr[2]), .rx_frame_err(rx_ferr[2]),
    .rx_overrun(rx_ovr[2]), .rx_busy(rx_busy[2]));

  uart_rx_param #(.CLK_FREQ_HZ(20_000_000), .BAUD(256000), .DATA_BITS(5), .PARITY(0), .STOP_BITS(1)) u_dut3 (
    .SYS_CLK(clk), .RST_N(rst_n), .Rxd(rxd[3]), .rx_ready(ready[3]), .rx_data(rx_data[3]),
    .rx_valid(rx_valid[3]), .rx_parity_err(rx_perr[3]), .rx_frame_err(rx_ferr[3]),
    .rx_overrun(rx_ovr[3]), .rx_busy(rx_busy[3]));

  // Output monitor, sampled on the falling edge: records each rising edge of
  // rx_valid with its payload, the number of valid cycles and overrun pulses.
  int         cap_cnt  [NU];
  logic [7:0] cap_data [NU];
  logic       cap_perr [NU];
  logic       cap_ferr [NU];
  int         ovr_cnt  [NU];
  int         vcyc     [NU];
  bit         pv       [NU];

  always @(negedge clk) begin
    for (int u = 0; u < NU; u++) begin
      if (rx_valid[u] === 1'b1 && !pv[u]) begin
        cap_cnt[u]++;
        cap_data[u] = rx_data[u];
        cap_perr[u] = rx_perr[u];
        cap_ferr[u] = rx_ferr[u];
      end
      if (rx_valid[u] === 1'b1) vcyc[u]++;
      if (rx_ovr[u] === 1'b1) ovr_cnt[u]++;
      pv[u] = (rx_valid[u] === 1'b1);
    end
  end

  // Safety net: the run must always end on its own.
  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation did not reach its end within the time limit");
    $fatal(1);
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model: what the receiver should report for a given frame.
  function automatic logic [7:0] exp_data(input int u, input logic [7:0] d);
    return d & 8'((1 << NB[u]) - 1);
  endfunction

  function automatic logic exp_perr(input int u, input logic [7:0] d, input logic pbit);
    int ones;
    if (PM[u] == 0) return 1'b0;
    ones = $countones(exp_data(u, d)) + int'(pbit);
    return (PM[u] == 1) ? (ones % 2 != 0) : (ones % 2 == 0);
  endfunction

  function automatic logic exp_ferr(input int u, input logic [1:0] stops);
    for (int i = 0; i < NS[u]; i++) begin
      if (!stops[i]) return 1'b1;
    end
    return 1'b0;
  endfunction

  // Line image of one frame, bit 0 first on the wire.
  task automatic build_frame(input int u, input logic [7:0] d, input logic pbit,
                             input logic [1:0] stops, output logic [15:0] bits, output int len);
    bits = '1;
    len  = 0;
    bits[len] = 1'b0;
    len++;
    for (int i = 0; i < NB[u]; i++) begin
      bits[len] = d[i];
      len++;
    end
    if (PM[u] != 0) begin
      bits[len] = pbit;
      len++;
    end
    for (int i = 0; i < NS[u]; i++) begin
      bits[len] = stops[i];
      len++;
    end
  endtask

  // Drive line bits [first, last); bit 'spike' gets a 1-cycle high pulse at HALF.
  task automatic drive_bits(input int u, input logic [15:0] bits, input int first,
                            input int last, input int spike);
    for (int i = first; i < last; i++) begin
      for (int c = 0; c < BIT_CNT; c++) begin
        rxd[u] = (i == spike && c == HALF) ? 1'b1 : bits[i];
        wait_cycles(1);
      end
    end
  endtask

  // Send one frame with ready high and compare the delivered byte with the model.
  task automatic send_check(input int u, input logic [7:0] d, input logic pbit,
                            input logic [1:0] stops, input int spike, input string tag);
    logic [15:0] bits;
    int          len;
    int          c0;
    int          v0;
    c0 = cap_cnt[u];
    v0 = vcyc[u];
    build_frame(u, d, pbit, stops, bits, len);
    drive_bits(u, bits, 0, len, spike);
    rxd[u] = 1'b1;
    wait_cycles(BIT_CNT);
    check({tag, " frames"}, cap_cnt[u] - c0, 1);
    check({tag, " data"}, cap_data[u], exp_data(u, d));
    check({tag, " parity_err"}, cap_perr[u], exp_perr(u, d, pbit));
    check({tag, " frame_err"}, cap_ferr[u], exp_ferr(u, stops));
    check({tag, " valid_cycles"}, vcyc[u] - v0, 1);
    check({tag, " busy"}, rx_busy[u], 0);
  endtask

  initial begin
    logic [15:0] bits;
    logic [15:0] bits2;
    int          len;
    int          len2;
    int          c0;
    int          v0;
    int          o0;
    logic [7:0]  d;
    logic        pbit;
    logic [1:0]  stops;

    for (int u = 0; u < NU; u++) begin
      rxd[u]   = 1'b1;
      ready[u] = 1'b1;
    end

    // Reset state.
    rst_n = 1'b0;
    wait_cycles(5);
    for (int u = 0; u < NU; u++) begin
      check($sformatf("reset u%0d outputs", u),
            {rx_data[u], rx_valid[u], rx_perr[u], rx_ferr[u], rx_ovr[u], rx_busy[u]}, 0);
    end
    rst_n = 1'b1;
    wait_cycles(BIT_CNT);
    check("post-reset u0 busy", rx_busy[0], 0);
    check("post-reset u0 valid", rx_valid[0], 0);

    // 8N1 basic frame.
    send_check(0, 8'hA5, 1'b0, 2'b11, -1, "8N1 0xA5");

    // Even parity: 0x07 has three ones, so parity bit 0 is wrong and 1 is right.
    send_check(1, 8'h07, 1'b0, 2'b11, -1, "even 0x07 p0");
    send_check(1, 8'h07, 1'b1, 2'b11, -1, "even 0x07 p1");

    // Short low glitch on an idle line: rejected as a false start.
    c0 = cap_cnt[0];
    v0 = vcyc[0];
    rxd[0] = 1'b0;
    wait_cycles(10);
    check("glitch busy during", rx_busy[0], 1);
    wait_cycles(10);
    rxd[0] = 1'b1;
    wait_cycles(2 * BIT_CNT);
    check("glitch busy after", rx_busy[0], 0);
    check("glitch no frame", cap_cnt[0] - c0, 0);
    check("glitch no valid", vcyc[0] - v0, 0);

    // One-cycle high spike in the centre of data bit 3 (line bit 4) of 0x00.
    send_check(0, 8'h00, 1'b0, 2'b11, 4, "spike 0x00");

    // Overrun: ready low, two back-to-back frames; the first one is kept.
    ready[0] = 1'b0;
    c0 = cap_cnt[0];
    o0 = ovr_cnt[0];
    build_frame(0, 8'h11, 1'b0, 2'b11, bits, len);
    build_frame(0, 8'h22, 1'b0, 2'b11, bits2, len2);
    drive_bits(0, bits, 0, len, -1);
    drive_bits(0, bits2, 0, len2, -1);
    rxd[0] = 1'b1;
    wait_cycles(BIT_CNT);
    check("overrun frames", cap_cnt[0] - c0, 1);
    check("overrun held data", rx_data[0], 8'h11);
    check("overrun valid held", rx_valid[0], 1);
    check("overrun pulses", ovr_cnt[0] - o0, 1);
    ready[0] = 1'b1;
    check("accept valid before edge", rx_valid[0], 1);
    wait_cycles(1);
    check("accept valid cleared", rx_valid[0], 0);

    // Two stop bits with the second one low: data delivered, frame error set.
    // 0x3C has four ones, so odd parity needs parity bit 1.
    send_check(2, 8'h3C, 1'b1, 2'b01, -1, "2stop 0x3C");

    // Five data bits.
    send_check(3, 8'h1F, 1'b0, 2'b11, -1, "5bit 0x1F");
    send_check(3, 8'hFF, 1'b0, 2'b11, -1, "5bit 0xFF");

    // Break: line held low for many bit times gives exactly one frame.
    c0 = cap_cnt[0];
    rxd[0] = 1'b0;
    wait_cycles(12 * BIT_CNT);
    check("break frames", cap_cnt[0] - c0, 1);
    check("break data", cap_data[0], 8'h00);
    check("break frame_err", cap_ferr[0], 1);
    check("break busy while low", rx_busy[0], 0);
    rxd[0] = 1'b1;
    wait_cycles(2 * BIT_CNT);
    check("break no extra frame", cap_cnt[0] - c0, 1);

    // Randomised frames on every format.
    for (int u = 0; u < NU; u++) begin
      for (int k = 0; k < 3; k++) begin
        d        = 8'($urandom);
        pbit     = 1'($urandom_range(0, 1));
        stops[0] = ($urandom_range(0, 3) != 0);
        stops[1] = ($urandom_range(0, 3) != 0);
        send_check(u, d, pbit, stops, -1, $sformatf("rand u%0d #%0d d=%02h", u, k, d));
      end
    end

    // Reset in the middle of data bit 4 while a byte is held.
    ready[0] = 1'b0;
    build_frame(0, 8'h99, 1'b0, 2'b11, bits, len);
    drive_bits(0, bits, 0, len, -1);
    rxd[0] = 1'b1;
    wait_cycles(BIT_CNT);
    check("pre-reset held valid", rx_valid[0], 1);
    build_frame(0, 8'hC3, 1'b0, 2'b11, bits, len);
    drive_bits(0, bits, 0, 5, -1);
    rxd[0] = bits[5];
    wait_cycles(HALF);
    check("pre-reset busy", rx_busy[0], 1);
    rst_n = 1'b0;
    #1;
    check("mid-frame reset outputs",
          {rx_data[0], rx_valid[0], rx_perr[0], rx_ferr[0], rx_ovr[0], rx_busy[0]}, 0);
    wait_cycles(3);
    rxd[0]   = 1'b1;
    ready[0] = 1'b1;
    rst_n    = 1'b1;
    wait_cycles(2 * BIT_CNT);
    check("post-abort no valid", rx_valid[0], 0);
    send_check(0, 8'h5A, 1'b0, 2'b11, -1, "after reset 0x5A");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
